// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush sequencing for the 5-stage pipe plus MULT/DIV issue/busy/done.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_md,
    input  logic       id_reads_hilo,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_redirect,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       md_issue,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

    state_t     r_state, w_state_next;
    logic [5:0] r_cnt, w_cnt_next;
    logic       r_run;
    logic       r_md_done, w_md_done_next;
    logic       w_lu_haz, w_md_haz, w_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_run     <= 1'b1;
            r_md_done <= w_md_done_next;
        end
    end

    assign md_busy = (r_state == MD_BUSY);
    assign md_done = r_md_done;

    // A load to $zero never produces a value worth waiting for.
    assign w_lu_haz = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    assign w_md_haz = md_busy && (id_is_md || id_reads_hilo);
    assign w_stall  = w_lu_haz || w_md_haz;

    always_comb begin
        pc_write       = 1'b0;
        ifid_write     = 1'b0;
        ifid_flush     = 1'b1;
        idex_bubble    = 1'b1;
        md_issue       = 1'b0;
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_md_done_next = 1'b0;

        if (r_run) begin
            if (ex_redirect) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_stall) begin
                ifid_flush  = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b0;
                idex_bubble = 1'b0;
                md_issue    = id_is_md;
            end
        end

        // Redirects never abort an in-flight MULT/DIV: it is older than the branch.
        if (r_state == IDLE) begin
            if (md_issue) begin
                w_state_next = MD_BUSY;
                w_cnt_next   = 6'(MD_LATENCY - 1);
            end
        end else begin
            if (r_cnt != 6'd0) begin
                w_cnt_next = r_cnt - 6'd1;
            end else begin
                w_state_next   = IDLE;
                w_md_done_next = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles, r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (r_run && !ex_redirect && w_stall && !(&r_stall_cycles))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (r_run && ex_redirect && !(&r_flush_count))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed test-plan scenarios then randomized traffic
// against a cycle-count reference model; perf counters are also checked when HAZARD_PERF_EN is defined.
module tb_hazard_stall_ctrl;
    localparam int L    = 32;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, id_is_md = 0, id_reads_hilo = 0;
    logic       ex_mem_read = 0, ex_redirect = 0;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, md_issue, md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cycles, flush_count;
`endif

    hazard_stall_ctrl #(.MD_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_issue(md_issue), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    // ctl order: {pc_write, ifid_write, ifid_flush, idex_bubble, md_issue, md_busy, md_done}
    typedef struct packed {
        logic [6:0] ctl;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Reference model: cycles of MULT/DIV busy remaining, done flag, run flag, event counts.
    bit m_run = 0;
    int m_left = 0;
    bit m_done = 0;
    int m_sc = 0, m_fc = 0;
    bit p_issue = 0, p_stall_ev = 0, p_flush_ev = 0;

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic md, input logic hilo,
                        input logic mr, input logic [4:0] ert, input logic redir);
        exp_t e;
        bit busy, lu, stall;
        bit pc, ifw, fl, bub, iss;
        @(posedge clk);
        #1;
        if (rst) begin
            if (m_run) begin
                if (p_flush_ev && m_fc < CMAX) m_fc++;
                if (p_stall_ev && m_sc < CMAX) m_sc++;
            end
            if (m_left > 0) begin
                m_done = (m_left == 1);
                m_left--;
            end else begin
                m_done = 0;
                if (p_issue) m_left = L;
            end
            m_run = 1;
        end
        rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_is_md = md; id_reads_hilo = hilo; ex_mem_read = mr; ex_rt = ert; ex_redirect = redir;
        if (!r) begin
            m_run = 0; m_left = 0; m_done = 0; m_sc = 0; m_fc = 0;
        end
        busy  = (m_left > 0);
        lu    = mr && (ert != 0) && ((urs && rs == ert) || (urt && rt == ert));
        stall = lu || (busy && (md || hilo));
        if (!m_run)     {pc, ifw, fl, bub, iss} = 5'b00110;
        else if (redir) {pc, ifw, fl, bub, iss} = 5'b11110;
        else if (stall) {pc, ifw, fl, bub, iss} = 5'b00010;
        else            {pc, ifw, fl, bub, iss} = {4'b1100, md};
        p_issue    = iss;
        p_stall_ev = m_run && !redir && stall;
        p_flush_ev = m_run && redir;
        e.ctl = {pc, ifw, fl, bub, iss, busy, m_done};
        e.sc  = m_sc;
        e.fc  = m_fc;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [6:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_bubble, md_issue, md_busy, md_done};
            n_txn++;
            n_checks++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl txn %0d: got %b expected %b (pc,ifw,flush,bubble,issue,busy,done)",
                         n_txn, act, e.ctl);
            end else begin
                $display("txn %0d ctl=%b ok", n_txn, act);
            end
`ifdef HAZARD_PERF_EN
            n_checks++;
            if (int'(stall_cycles) != e.sc || int'(flush_count) != e.fc) begin
                n_fail++;
                $display("FAIL perf txn %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         n_txn, stall_cycles, flush_count, e.sc, e.fc);
            end
`endif
        end
    end

    initial begin
        // Reset held, then release: first cycle still frozen, next cycle normal flow.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Load-use on rs, then clear, then load to $zero (no stall).
        step(1, 8, 0, 1, 0, 0, 0, 1, 8, 0);
        idle(1);
        step(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 3, 9, 0, 1, 0, 0, 1, 9, 0);
        step(1, 9, 4, 0, 1, 0, 0, 1, 9, 0);
        idle(1);

        // MULT issue, then MFHI held in ID through busy and the done cycle.
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < L + 1; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Redirect together with a load-use hazard.
        step(1, 8, 0, 1, 0, 0, 0, 1, 8, 1);
        idle(1);

        // Reset in the tenth busy cycle: busy drops at once, no done pulse afterwards.
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Three load-use stalls and two redirects since reset.
        step(1, 5, 0, 1, 0, 0, 0, 1, 5, 0);
        idle(1);
        step(1, 0, 6, 0, 1, 0, 0, 1, 6, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 7, 0, 1, 0, 0, 0, 1, 7, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(L + 4);
`ifdef HAZARD_PERF_EN
        @(negedge clk);
        #1;
        n_checks++;
        if (stall_cycles != CW'(3) || flush_count != CW'(2)) begin
            n_fail++;
            $display("FAIL perf_totals: got stall=%0d flush=%0d expected stall=3 flush=2",
                     stall_cycles, flush_count);
        end
`endif

        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 149) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected transactions never compared, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
